mem_block_copier: RTL and testbench

//  Bus initiator for the data memory's MEM_WRITE/MEM_READ/ADDRESS/WRITE_DATA/READ_DATA interface.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_addr_stepper.sv | 58 +++++
 rtl/mem_block_copier.sv | 192 +++++++++++++++++++
 tb/tb_mem_block_copier.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the block copier: FSM states, default memory
// depth and copy-direction encoding.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam int unsigned MEM_DEPTH_DEF = 128;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/mem_addr_stepper.sv
// Word-offset counter for the copier: loads the start offset for the chosen
// direction, steps once per written word and presents the next src/dst addresses.
module mem_addr_stepper
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_dir,
    input  logic              step,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] src_sum,
    output logic [ADDR_W-1:0] dst_sum,
    output logic              last
);

    logic [LEN_W-1:0] off_r;
    logic [LEN_W-1:0] off_s;
    logic             dir_r;

    // Offset the counter will hold after this edge; the sums use it so the
    // registered address in the top is aligned with the state being entered.
    always_comb begin
        off_s = off_r;
        if (load) begin
            off_s = (load_dir == DIR_DESC) ? (len - LEN_W'(1)) : '0;
        end else if (step) begin
            off_s = (dir_r == DIR_DESC) ? (off_r - LEN_W'(1)) : (off_r + LEN_W'(1));
        end else begin
            off_s = off_r;
        end
    end

    // Offset and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_r <= '0;
            dir_r <= DIR_ASC;
        end else begin
            off_r <= off_s;
            if (load) begin
                dir_r <= load_dir;
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    assign src_sum = src_base + ADDR_W'(off_s);
    assign dst_sum = dst_base + ADDR_W'(off_s);
    assign last    = (dir_r == DIR_DESC) ? (off_r == '0) : (off_r == (len - LEN_W'(1)));

endmodule

// File: rtl/mem_block_copier.sv
// Memory block copier (memmove semantics): range-checks the request, then moves
// one word per read/write cycle pair through a single data buffer.
module mem_block_copier
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  word_count,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    state_e            state_r, state_s;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [LEN_W-1:0]  len_r;
    logic              abort_pend_r;
    logic [DATA_W-1:0] data_buf_r;
    logic              busy_r, done_r, error_r, mem_read_r, mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [LEN_W-1:0]  word_count_r;

    logic [ADDR_W:0]   src_end_s, dst_end_s;
    logic              range_err_s, desc_s, load_s, step_s, error_s, accept_s;
    logic [ADDR_W-1:0] src_sum_s, dst_sum_s;
    logic              last_s;

    // Ends are formed one bit wider so a request near the top cannot wrap into range.
    assign src_end_s   = {1'b0, src_r} + (ADDR_W+1)'(len_r);
    assign dst_end_s   = {1'b0, dst_r} + (ADDR_W+1)'(len_r);
    assign range_err_s = (src_end_s > DEPTH_LIM) || (dst_end_s > DEPTH_LIM);
    assign desc_s      = (dst_r > src_r) && ({1'b0, dst_r} < src_end_s);
    assign accept_s    = (state_r == ST_IDLE) && start;

    mem_addr_stepper #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_stepper (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_dir (desc_s ? DIR_DESC : DIR_ASC),
        .step     (step_s),
        .len      (len_r),
        .src_base (src_r),
        .dst_base (dst_r),
        .src_sum  (src_sum_s),
        .dst_sum  (dst_sum_s),
        .last     (last_s)
    );

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        error_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (len_r == '0) begin
                    state_s = ST_FIN;
                end else if (range_err_s) begin
                    state_s = ST_IDLE;
                    error_s = 1'b1;
                end else begin
                    state_s = ST_RD;
                    load_s  = 1'b1;
                end
            end
            ST_RD: begin
                state_s = ST_WR;
            end
            ST_WR: begin
                step_s = 1'b1;
                if (last_s || abort || abort_pend_r) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, request latches and data buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            src_r        <= '0;
            dst_r        <= '0;
            len_r        <= '0;
            abort_pend_r <= 1'b0;
            data_buf_r   <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                src_r <= src_addr;
                dst_r <= dst_addr;
                len_r <= len;
            end else begin
                src_r <= src_r;
                dst_r <= dst_r;
                len_r <= len_r;
            end
            // An abort seen during a read is remembered so its write still happens.
            if (state_r == ST_IDLE) begin
                abort_pend_r <= 1'b0;
            end else if ((state_r == ST_RD) && abort) begin
                abort_pend_r <= 1'b1;
            end else begin
                abort_pend_r <= abort_pend_r;
            end
            if (state_r == ST_RD) begin
                data_buf_r <= mem_rdata;
            end else begin
                data_buf_r <= data_buf_r;
            end
        end
    end

    // Output registers, loaded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            word_count_r <= '0;
        end else begin
            busy_r      <= (state_s == ST_CHECK) || (state_s == ST_RD) || (state_s == ST_WR);
            done_r      <= (state_s == ST_FIN);
            error_r     <= error_s;
            mem_read_r  <= (state_s == ST_RD);
            mem_write_r <= (state_s == ST_WR);
            if (state_s == ST_RD) begin
                mem_addr_r <= src_sum_s;
            end else if (state_s == ST_WR) begin
                mem_addr_r <= dst_sum_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (accept_s) begin
                word_count_r <= '0;
            end else if (state_r == ST_WR) begin
                word_count_r <= word_count_r + LEN_W'(1);
            end else begin
                word_count_r <= word_count_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = data_buf_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier: a transfer-level model predicts every
// output cycle and the final memory image; directed cases pin the model.
module tb_mem_block_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [7:0]  len = 8'd0;
    logic        busy, done, error, mem_read, mem_write;
    logic [7:0]  word_count;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_block_copier dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error), .word_count(word_count),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    logic [31:0] snap    [128];

    assign mem_rdata = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_write && (mem_addr < 32'd128)) mem[mem_addr[6:0]] <= mem_wdata;
    end

    typedef struct packed {
        logic [4:0]  flags;   // {busy, done, error, mem_read, mem_write}
        logic [7:0]  wc;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        first;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  idle_wc = 8'd0;
    logic        chk_en = 1'b0;
    int          cyc_idx = 0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    logic [31:0] first_rd_addr = 32'hFFFF_FFFF;
    logic        any_strobe = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model's expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.first) begin
                    cyc_idx = 0; done_cyc = -1; err_cyc = -1;
                    first_rd_addr = 32'hFFFF_FFFF; any_strobe = 1'b0;
                end else begin
                    cyc_idx++;
                end
            end else begin
                e = '0;
                e.wc = idle_wc;
                cyc_idx++;
            end
            chk("ctrl", {59'd0, busy, done, error, mem_read, mem_write}, {59'd0, e.flags});
            chk("word_count", {56'd0, word_count}, {56'd0, e.wc});
            if (e.chk_addr)  chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
            if (e.chk_wdata) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
            if (done && done_cyc < 0) done_cyc = cyc_idx;
            if (error && err_cyc < 0) err_cyc = cyc_idx;
            if (mem_read && first_rd_addr == 32'hFFFF_FFFF) first_rd_addr = mem_addr;
            if (mem_read || mem_write) any_strobe = 1'b1;
        end
    end

    // Transfer-level model: pushes the expected output of every cycle from
    // START (index 0) to the end cycle and applies the words to ref_mem.
    task automatic model_xfer(input int s, input int d, input int l, input int ab_cyc, output int ncyc);
        exp_t e;
        int   k, o;
        bit   desc;
        e = '0; e.wc = idle_wc; e.first = 1'b1;
        exp_q.push_back(e);
        e = '0; e.flags = 5'b10000; e.wc = 8'd0;
        exp_q.push_back(e);
        ncyc = 2;
        if (l == 0) begin
            e = '0; e.flags = 5'b01000; exp_q.push_back(e); ncyc++;
            idle_wc = 8'd0;
        end else if (s + l > 128 || d + l > 128) begin
            e = '0; e.flags = 5'b00100; exp_q.push_back(e); ncyc++;
            idle_wc = 8'd0;
        end else begin
            desc = (d > s) && (d < s + l);
            k = l;
            if (ab_cyc >= 2 && ab_cyc < 2 + 2*l) k = (ab_cyc - 2) / 2 + 1;
            for (int i = 0; i < k; i++) begin
                o = desc ? (l - 1 - i) : i;
                e = '0; e.flags = 5'b10010; e.wc = 8'(i); e.chk_addr = 1'b1; e.addr = 32'(s + o);
                exp_q.push_back(e);
                e = '0; e.flags = 5'b10001; e.wc = 8'(i); e.chk_addr = 1'b1; e.addr = 32'(d + o);
                e.chk_wdata = 1'b1; e.wdata = ref_mem[s + o];
                exp_q.push_back(e);
                ref_mem[d + o] = ref_mem[s + o];
                ncyc += 2;
            end
            e = '0; e.flags = 5'b01000; e.wc = 8'(k); exp_q.push_back(e); ncyc++;
            idle_wc = 8'(k);
        end
    endtask

    task automatic run_xfer(input int s, input int d, input int l, input int ab_cyc, input int extra);
        int n;
        @(posedge clk); #1;
        model_xfer(s, d, l, ab_cyc, n);
        src_addr = 32'(s); dst_addr = 32'(d); len = 8'(l);
        start = 1'b1; abort = (ab_cyc == 0);
        for (int c = 1; c < n; c++) begin
            @(posedge clk); #1;
            start = (c == extra);
            abort = (c == ab_cyc);
            if (start) begin
                src_addr = $urandom_range(0, 127); dst_addr = $urandom_range(0, 127);
                len = 8'($urandom_range(1, 20));
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_mem(input string nm);
        int mism, first_bad;
        mism = 0; first_bad = -1;
        for (int i = 0; i < 128; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk(nm, 64'(mism), 64'd0);
        if (mism != 0) $display("  first differing word %0d: %0h vs %0h", first_bad, mem[first_bad], ref_mem[first_bad]);
    endtask

    initial begin
        int s, d, l, ab, ex;
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        #1;
        chk("reset_outputs", {56'd0, busy, done, error, mem_read, mem_write, 3'd0},
            {64'd0});
        chk("reset_addr_wc", {mem_addr, 24'd0, word_count}, 64'd0);
        #20; rst_n = 1'b1;
        @(posedge clk); #1; chk_en = 1'b1;

        // 1: plain ascending copy
        for (int i = 0; i < 4; i++) begin
            mem[10+i] = 32'hA0 + 32'(i); ref_mem[10+i] = 32'hA0 + 32'(i);
        end
        run_xfer(10, 40, 4, -1, 3);
        for (int i = 0; i < 4; i++) chk("t1_dst_word", {32'd0, mem[40+i]}, 64'h0A0 + 64'(i));
        chk("t1_done_cycle", 64'(done_cyc), 64'd10);
        chk("t1_word_count", {56'd0, word_count}, 64'd4);
        chk_mem("t1_mem");

        // 2: overlapping copy runs descending
        for (int i = 0; i < 4; i++) begin
            mem[20+i] = 32'(i + 1); ref_mem[20+i] = 32'(i + 1);
        end
        run_xfer(20, 22, 4, -1, 1);
        for (int i = 0; i < 4; i++) chk("t2_dst_word", {32'd0, mem[22+i]}, 64'(i + 1));
        chk("t2_first_addr", {32'd0, first_rd_addr}, 64'd23);
        chk_mem("t2_mem");

        // 3: zero length
        run_xfer(5, 9, 0, 1, 1);
        chk("t3_done_cycle", 64'(done_cyc), 64'd2);
        chk("t3_no_strobe", {63'd0, any_strobe}, 64'd0);
        chk("t3_word_count", {56'd0, word_count}, 64'd0);

        // 4: out-of-range source
        run_xfer(126, 0, 4, -1, 1);
        chk("t4_err_cycle", 64'(err_cyc), 64'd2);
        chk("t4_no_strobe", {63'd0, any_strobe}, 64'd0);
        chk("t4_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_busy_low", {63'd0, busy}, 64'd0);

        // 5: abort during the second read
        for (int i = 0; i < 128; i++) snap[i] = mem[i];
        run_xfer(30, 50, 8, 4, 2);
        chk("t5_word_count", {56'd0, word_count}, 64'd2);
        chk("t5_done_cycle", 64'(done_cyc), 64'd6);
        for (int i = 2; i < 8; i++) chk("t5_untouched", {32'd0, mem[50+i]}, {32'd0, snap[50+i]});
        chk("t5_word0", {32'd0, mem[50]}, {32'd0, snap[30]});
        chk_mem("t5_mem");

        // 6: reset during the third write
        for (int i = 0; i < 128; i++) snap[i] = ref_mem[i];
        fork
            run_xfer(60, 70, 8, -1, 3);
            begin
                repeat (8) @(posedge clk);
                #2;
                chk_en = 1'b0; rst_n = 1'b0;
                #1;
                chk("t6_rst_write", {63'd0, mem_write}, 64'd0);
                chk("t6_rst_busy_done", {62'd0, busy, done}, 64'd0);
            end
        join_any
        disable fork;
        start = 1'b0; abort = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 128; i++) ref_mem[i] = snap[i];
        for (int i = 0; i < 2; i++) ref_mem[70+i] = ref_mem[60+i];
        idle_wc = 8'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; chk_en = 1'b1;
        chk_mem("t6_partial_mem");
        run_xfer(0, 100, 5, -1, 4);
        chk("t6_restart_wc", {56'd0, word_count}, 64'd5);
        chk_mem("t6_restart_mem");

        // random transfers
        for (int t = 0; t < 40; t++) begin
            s = $urandom_range(0, 127);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) d = s + $urandom_range(0, 10) - 5;
            else d = $urandom_range(0, 127);
            if (d < 0) d = 0;
            if (d > 127) d = 127;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 + 2*l) : -1;
            ex = 1;
            if (l > 0 && s + l <= 128 && d + l <= 128) ex = $urandom_range(1, 2 * l);
            run_xfer(s, d, l, ab, ex);
            chk_mem("rand_mem");
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
